alu_arbiter: RTL

- Shares the single 16-bit ALU (ops: 0 ADD, 1 SUB, 2 SLL, 3 AND) between two requesters, e.g. the execute stage and an address-generation unit.
- Accepts one operation at a time using a valid/ready handshake, with round-robin arbitration between the two ports.
- Drives the ALU operand and opcode inputs from registers, captures the ALU result, and returns it to the granted port with its own response handshake.

---
 rtl/alu_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_pkg
//  Description : Opcode constants and FSM state encoding for alu_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_LAST = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin picker.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    assign grant_valid = |req;
    // On a tie the port that was not served last wins.
    assign grant_id    = (req == 2'b11) ? ~last_grant : req[1];

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one external 16-bit ALU between two requesters with
//                round-robin arbitration and per-port response handshakes.
//                Optional macro ALU_ARB_OPCHK_EN: illegal opcodes bypass the
//                ALU and return resp_err=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,

    output logic              busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_grant;
    logic              r_gid;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;

    logic              w_grant_valid;
    logic              w_grant_id;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [OP_W-1:0]   w_sel_op;
    logic              w_illegal;
    logic              w_resp_ack;

    rr_arb2 u_rr_arb2 (
        .req         ({req1_valid, req0_valid}),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    assign w_sel_a    = w_grant_id ? req1_a  : req0_a;
    assign w_sel_b    = w_grant_id ? req1_b  : req0_b;
    assign w_sel_op   = w_grant_id ? req1_op : req0_op;
    assign w_resp_ack = r_gid ? resp1_ready : resp0_ready;

`ifdef ALU_ARB_OPCHK_EN
    assign w_illegal = (w_sel_op > OP_W'(OP_LAST));
`else
    assign w_illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                // Ready is masked during reset so no request is acknowledged
                // for a cycle whose accept edge is discarded.
                req0_ready = !rst && w_grant_valid && !w_grant_id;
                req1_ready = !rst && w_grant_valid &&  w_grant_id;
                if (w_grant_valid) begin
                    w_state_next = w_illegal ? RESP : EXEC;
                end
            end
            EXEC: begin
                w_state_next = RESP;
            end
            RESP: begin
                resp0_valid = !r_gid;
                resp1_valid =  r_gid;
                if (w_resp_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_gid        <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_gid <= w_grant_id;
                        if (w_illegal) begin
                            r_resp_data <= '0;
                            r_resp_err  <= 1'b1;
                        end else begin
                            r_alu_a  <= w_sel_a;
                            r_alu_b  <= w_sel_b;
                            r_alu_op <= w_sel_op;
                        end
                    end
                end
                EXEC: begin
                    r_resp_data <= alu_result;
                    r_resp_err  <= 1'b0;
                end
                RESP: begin
                    if (w_resp_ack) begin
                        r_last_grant <= r_gid;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign resp_data = r_resp_data;
    assign resp_err  = r_resp_err;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
